// File: rtl/product_accumulator_pkg.sv
// Shared types and defaults for the product accumulator slice.
// State encoding, frame id width and default widths.
package product_accumulator_pkg;

    localparam int FRAME_ID_W = 4;
    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 12;
    localparam int LEN_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned saturating adder: clamps to all-ones on carry out.
// Purely combinational.
module sat_adder #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sat  = full[W];
    assign sum  = sat ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums LEN products per frame into a saturated, frame-tagged result
// presented with a valid/ready handshake.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN    = LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_W-1:0]     product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      acc_out,
    output logic                  overflow,
    output logic [FRAME_ID_W-1:0] frame_id
);

    localparam int              CNT_W    = $clog2(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    state_e                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sticky_q, sticky_d;
    logic [ACC_W-1:0]        acc_out_q, acc_out_d;
    logic                    overflow_q, overflow_d;
    logic                    out_valid_q, out_valid_d;
    logic [FRAME_ID_W-1:0]   frame_id_q, frame_id_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             sat;
    logic             sticky_eff;

    assign prod_ext = ACC_W'(product);

    sat_adder #(.W(ACC_W)) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (sum),
        .sat (sat)
    );

    // The sticky flag restarts with the first beat of every frame.
    assign sticky_eff = (state_q == ST_IDLE) ? 1'b0 : sticky_q;

    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign overflow  = overflow_q;
    assign frame_id  = frame_id_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        acc_out_d   = acc_out_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        frame_id_d  = frame_id_q;

        if (clear) begin
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == CNT_LAST) begin
                            acc_out_d   = sum;
                            overflow_d  = sticky_eff | sat;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            sticky_d    = 1'b0;
                            frame_id_d  = frame_id_q + FRAME_ID_W'(1);
                            state_d     = ST_DONE;
                        end else begin
                            acc_d    = sum;
                            cnt_d    = cnt_q + CNT_W'(1);
                            sticky_d = sticky_eff | sat;
                            state_d  = ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    acc_d       = '0;
                    cnt_d       = '0;
                    sticky_d    = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            acc_out_q   <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            acc_out_q   <= acc_out_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            frame_id_q  <= frame_id_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: default instance plus an ACC_W=10, LEN=8 instance
// for saturation.
module tb_product_accumulator;

    typedef struct {
        int acc;
        int ovf;
        int fid;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_product;
    logic [11:0] a_acc_out;
    logic        a_overflow;
    logic [3:0]  a_frame_id;

    logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_product;
    logic [9:0]  b_acc_out;
    logic        b_overflow;
    logic [3:0]  b_frame_id;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    product_accumulator dut_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .product(a_product),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .acc_out(a_acc_out), .overflow(a_overflow), .frame_id(a_frame_id)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(10), .LEN(8)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .product(b_product),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .acc_out(b_acc_out), .overflow(b_overflow), .frame_id(b_frame_id)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_a(input int acc, input int ovf, input int fid);
        exp_t e;
        e.acc = acc; e.ovf = ovf; e.fid = fid;
        qa.push_back(e);
    endtask

    task automatic push_b(input int acc, input int ovf, input int fid);
        exp_t e;
        e.acc = acc; e.ovf = ovf; e.fid = fid;
        qb.push_back(e);
    endtask

    // Handshake completes on the next posedge, so negedge sampling is safe.
    always @(negedge clk) begin
        if (!rst && !a_clear && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got acc %0d expected no result",
                         a_acc_out);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_acc", int'(a_acc_out), e.acc);
                chk("a_ovf", int'(a_overflow), e.ovf);
                chk("a_fid", int'(a_frame_id), e.fid);
            end
        end
        if (!rst && !b_clear && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got acc %0d expected no result",
                         b_acc_out);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_acc", int'(b_acc_out), e.acc);
                chk("b_ovf", int'(b_overflow), e.ovf);
                chk("b_fid", int'(b_frame_id), e.fid);
            end
        end
    end

    task automatic beat_a(input logic [7:0] p);
        int n;
        a_in_valid = 1'b1;
        a_product  = p;
        @(negedge clk);
        n = 0;
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) chk("a_beat_timeout", 0, 1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic beat_b(input logic [7:0] p);
        int n;
        b_in_valid = 1'b1;
        b_product  = p;
        @(negedge clk);
        n = 0;
        while (!b_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) chk("b_beat_timeout", 0, 1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic check_a_idle(input string tag, input int acc, input int fid);
        chk({tag, "_out_valid"}, int'(a_out_valid), 0);
        chk({tag, "_in_ready"}, int'(a_in_ready), 1);
        chk({tag, "_acc_out"}, int'(a_acc_out), acc);
        chk({tag, "_frame_id"}, int'(a_frame_id), fid);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_clear = 0; a_in_valid = 0; a_out_ready = 1; a_product = '0;
        b_clear = 0; b_in_valid = 0; b_out_ready = 1; b_product = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_a_idle("reset", 0, 0);
        chk("reset_overflow", int'(a_overflow), 0);
        @(posedge clk); #1;

        // 1: basic frame, out_valid for exactly one cycle
        push_a(30, 0, 1);
        beat_a(1); beat_a(4); beat_a(9); beat_a(16);
        @(negedge clk);
        chk("t1_out_valid", int'(a_out_valid), 1);
        chk("t1_in_ready_done", int'(a_in_ready), 0);
        @(negedge clk);
        check_a_idle("t1_after", 30, 1);
        @(posedge clk); #1;

        // 2: second frame
        push_a(174, 0, 2);
        beat_a(25); beat_a(36); beat_a(49); beat_a(64);
        @(negedge clk);
        chk("t2_in_ready_done", int'(a_in_ready), 0);
        @(negedge clk);
        check_a_idle("t2_after", 174, 2);
        @(posedge clk); #1;

        // 3: back-pressure with a held beat
        push_a(8, 0, 3);
        push_a(7, 0, 4);
        beat_a(2); beat_a(2); beat_a(2); beat_a(2);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_product   = 8'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_valid", int'(a_out_valid), 1);
            chk("t3_stall_acc", int'(a_acc_out), 8);
            chk("t3_stall_fid", int'(a_frame_id), 3);
            chk("t3_stall_in_ready", int'(a_in_ready), 0);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        beat_a(7); beat_a(0); beat_a(0); beat_a(0);
        repeat (2) @(posedge clk); #1;

        // 5: clear mid-frame, same-cycle beat is dropped
        beat_a(10); beat_a(20);
        a_clear    = 1'b1;
        a_in_valid = 1'b1;
        a_product  = 8'd50;
        @(posedge clk); #1;
        a_clear    = 1'b0;
        a_in_valid = 1'b0;
        @(negedge clk);
        check_a_idle("t5_clear", 7, 4);
        @(posedge clk); #1;
        push_a(10, 0, 5);
        beat_a(1); beat_a(2); beat_a(3); beat_a(4);
        repeat (2) @(posedge clk); #1;

        // 4: saturation on the narrow instance, sticky cleared next frame
        push_b(1023, 1, 1);
        for (int i = 0; i < 8; i++) beat_b(225);
        @(negedge clk);
        chk("t4_b_valid", int'(b_out_valid), 1);
        @(posedge clk); #1;
        push_b(8, 0, 2);
        for (int i = 0; i < 8; i++) beat_b(1);
        repeat (2) @(posedge clk); #1;

        // 6: reset mid-frame, then frame id wrap
        beat_a(5); beat_a(5); beat_a(5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_a_idle("t6_rst", 0, 0);
        chk("t6_rst_overflow", int'(a_overflow), 0);
        @(posedge clk); #1;
        for (int k = 1; k <= 16; k++) begin
            push_a(4 * k, 0, k % 16);
            for (int j = 0; j < 4; j++) beat_a(8'(k));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_a_idle("t6_wrap", 64, 0);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
